// File: rtl/rvfi_packer.sv
// RVFI producer: compacts per-lane commit events into ordered rvfi_instr_t records,
// appends an exception trap record after the last commit, and registers everything.
package riscv;
    localparam int unsigned XLEN = 64;
    localparam int unsigned VLEN = 64;
endpackage

package rvfi_pkg;
    typedef struct packed {
        logic                     valid;
        logic [63:0]              order;
        logic [31:0]              insn;
        logic                     trap;
        logic [1:0]               mode;
        logic [4:0]               rd_addr;
        logic [riscv::XLEN-1:0]   rd_wdata;
        logic [riscv::VLEN-1:0]   pc_rdata;
    } rvfi_instr_t;
endpackage

module rvfi_packer #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned XLEN            = riscv::XLEN,
    parameter int unsigned VLEN            = riscv::VLEN
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [NR_COMMIT_PORTS-1:0]                   commit_valid_i,
    input  logic [NR_COMMIT_PORTS-1:0][VLEN-1:0]         commit_pc_i,
    input  logic [NR_COMMIT_PORTS-1:0][31:0]             commit_insn_i,
    input  logic [NR_COMMIT_PORTS-1:0][4:0]              commit_rd_i,
    input  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]         commit_wdata_i,
    input  logic                                         ex_valid_i,
    input  logic [VLEN-1:0]                              ex_pc_i,
    input  logic [31:0]                                  ex_insn_i,
    input  logic [1:0]                                   priv_lvl_i,
    output rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0]  rvfi_o,
    output logic [63:0]                                  instret_o,
    output logic                                         overflow_o
);
    localparam int unsigned CW = $clog2(NR_COMMIT_PORTS + 1);
    localparam int unsigned LW = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1;

    rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_d, rvfi_q;
    logic [63:0]   instret_q;
    logic          overflow_q;
    logic [CW-1:0] k;
    logic          trap_drop;

    // k doubles as the next free output lane while walking the input lanes.
    always_comb begin
        rvfi_d    = '0;
        k         = '0;
        trap_drop = 1'b0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (commit_valid_i[i]) begin
                rvfi_d[k[LW-1:0]].valid    = 1'b1;
                rvfi_d[k[LW-1:0]].order    = instret_q + 64'(k);
                rvfi_d[k[LW-1:0]].insn     = commit_insn_i[i];
                rvfi_d[k[LW-1:0]].mode     = priv_lvl_i;
                rvfi_d[k[LW-1:0]].rd_addr  = commit_rd_i[i];
                rvfi_d[k[LW-1:0]].rd_wdata = (commit_rd_i[i] == 5'd0) ? '0 : riscv::XLEN'(commit_wdata_i[i]);
                rvfi_d[k[LW-1:0]].pc_rdata = riscv::VLEN'(commit_pc_i[i]);
                k = k + CW'(1);
            end
        end
        if (ex_valid_i) begin
            if (k < CW'(NR_COMMIT_PORTS)) begin
                rvfi_d[k[LW-1:0]].trap     = 1'b1;
                rvfi_d[k[LW-1:0]].order    = instret_q + 64'(k);
                rvfi_d[k[LW-1:0]].insn     = ex_insn_i;
                rvfi_d[k[LW-1:0]].mode     = priv_lvl_i;
                rvfi_d[k[LW-1:0]].pc_rdata = riscv::VLEN'(ex_pc_i);
            end else begin
                trap_drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvfi_q     <= '0;
            instret_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            rvfi_q     <= rvfi_d;
            instret_q  <= instret_q + 64'(k);
            overflow_q <= overflow_q | trap_drop;
        end
    end

`ifndef SYNTHESIS
    // A trap with every lane retiring has nowhere to go; flag it loudly in simulation.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!trap_drop)
            else $warning("rvfi_packer: trap record dropped, all commit lanes busy");
        end
    end
`endif

    assign rvfi_o     = rvfi_q;
    assign instret_o  = instret_q;
    assign overflow_o = overflow_q;
endmodule

// File: tb/tb_rvfi_packer.sv
// Directed, table-driven check of rvfi_packer with two lanes and 64-bit XLEN/VLEN.
module tb_rvfi_packer;
    localparam int N = 2;
    typedef rvfi_pkg::rvfi_instr_t rec_t;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [N-1:0]            commit_valid_i;
    logic [N-1:0][63:0]      commit_pc_i;
    logic [N-1:0][31:0]      commit_insn_i;
    logic [N-1:0][4:0]       commit_rd_i;
    logic [N-1:0][63:0]      commit_wdata_i;
    logic                    ex_valid_i;
    logic [63:0]             ex_pc_i;
    logic [31:0]             ex_insn_i;
    logic [1:0]              priv_lvl_i;
    rec_t [N-1:0]            rvfi_o;
    logic [63:0]             instret_o;
    logic                    overflow_o;

    rvfi_packer #(.NR_COMMIT_PORTS(N), .XLEN(64), .VLEN(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i),
        .commit_insn_i(commit_insn_i), .commit_rd_i(commit_rd_i),
        .commit_wdata_i(commit_wdata_i), .ex_valid_i(ex_valid_i),
        .ex_pc_i(ex_pc_i), .ex_insn_i(ex_insn_i), .priv_lvl_i(priv_lvl_i),
        .rvfi_o(rvfi_o), .instret_o(instret_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [N-1:0]       cv;
        logic [N-1:0][63:0] pc;
        logic [N-1:0][31:0] insn;
        logic [N-1:0][4:0]  rd;
        logic [N-1:0][63:0] wd;
        logic               exv;
        logic [63:0]        expc;
        logic [31:0]        exinsn;
        logic [1:0]         priv;
        rec_t [N-1:0]       exp_rec;
        logic [63:0]        exp_instret;
        logic               exp_ovf;
    } vec_t;

    vec_t vecs[10];
    int   errors = 0;
    int   checks = 0;

    function automatic rec_t rec(input logic v, input logic t, input logic [63:0] ord,
                                 input logic [63:0] pc, input logic [31:0] insn,
                                 input logic [4:0] rd, input logic [63:0] wd,
                                 input logic [1:0] mode);
        rec_t r;
        r.valid = v; r.trap = t; r.order = ord; r.pc_rdata = pc; r.insn = insn;
        r.rd_addr = rd; r.rd_wdata = wd; r.mode = mode;
        return r;
    endfunction

    task automatic chk_rec(input string name, input rec_t [N-1:0] exp);
        checks++;
        if (rvfi_o !== exp) begin
            errors++;
            $display("FAIL %s: rvfi_o got %h expected %h", name, rvfi_o, exp);
        end
    endtask

    task automatic chk_u64(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        commit_valid_i = '0; commit_pc_i = '0; commit_insn_i = '0;
        commit_rd_i = '0; commit_wdata_i = '0; ex_valid_i = 1'b0;
        ex_pc_i = '0; ex_insn_i = '0; priv_lvl_i = 2'd3;
    endtask

    task automatic drive(input vec_t v);
        commit_valid_i = v.cv; commit_pc_i = v.pc; commit_insn_i = v.insn;
        commit_rd_i = v.rd; commit_wdata_i = v.wd; ex_valid_i = v.exv;
        ex_pc_i = v.expc; ex_insn_i = v.exinsn; priv_lvl_i = v.priv;
    endtask

    function automatic vec_t blank();
        vec_t v;
        v.cv = '0; v.pc = '0; v.insn = '0; v.rd = '0; v.wd = '0;
        v.exv = 1'b0; v.expc = '0; v.exinsn = '0; v.priv = 2'd3;
        v.exp_rec = '0; v.exp_instret = '0; v.exp_ovf = 1'b0;
        return v;
    endfunction

    rec_t [N-1:0] zero_recs;
    rec_t [N-1:0] tmp;

    initial begin
        zero_recs = '0;
        // 0: idle
        vecs[0] = blank();
        // 1: lane 0 only
        vecs[1] = blank();
        vecs[1].cv = 2'b01; vecs[1].pc[0] = 64'h80000000; vecs[1].insn[0] = 32'h00500093;
        vecs[1].rd[0] = 5'd1; vecs[1].wd[0] = 64'd5;
        vecs[1].exp_rec[0] = rec(1, 0, 0, 64'h80000000, 32'h00500093, 1, 5, 3);
        vecs[1].exp_instret = 1;
        // 2: lane 1 only, rd=0 suppresses wdata, compacted into lane 0
        vecs[2] = blank();
        vecs[2].cv = 2'b10; vecs[2].pc[1] = 64'h80000004; vecs[2].insn[1] = 32'h00000013;
        vecs[2].rd[1] = 5'd0; vecs[2].wd[1] = 64'hDEAD;
        vecs[2].exp_rec[0] = rec(1, 0, 1, 64'h80000004, 32'h00000013, 0, 0, 3);
        vecs[2].exp_instret = 2;
        // 3: both lanes
        vecs[3] = blank();
        vecs[3].cv = 2'b11;
        vecs[3].pc[0] = 64'h80000008; vecs[3].insn[0] = 32'h00100113; vecs[3].rd[0] = 2; vecs[3].wd[0] = 7;
        vecs[3].pc[1] = 64'h8000000C; vecs[3].insn[1] = 32'h00208193; vecs[3].rd[1] = 3; vecs[3].wd[1] = 9;
        vecs[3].exp_rec[0] = rec(1, 0, 2, 64'h80000008, 32'h00100113, 2, 7, 3);
        vecs[3].exp_rec[1] = rec(1, 0, 3, 64'h8000000C, 32'h00208193, 3, 9, 3);
        vecs[3].exp_instret = 4;
        // 4: lane 0 commit plus exception, user mode
        vecs[4] = blank();
        vecs[4].cv = 2'b01; vecs[4].pc[0] = 64'h8000000C; vecs[4].insn[0] = 32'h00400213;
        vecs[4].rd[0] = 4; vecs[4].wd[0] = 64'h11; vecs[4].priv = 2'd0;
        vecs[4].exv = 1; vecs[4].expc = 64'h80000010; vecs[4].exinsn = 32'h00000073;
        vecs[4].exp_rec[0] = rec(1, 0, 4, 64'h8000000C, 32'h00400213, 4, 64'h11, 0);
        vecs[4].exp_rec[1] = rec(0, 1, 5, 64'h80000010, 32'h00000073, 0, 0, 0);
        vecs[4].exp_instret = 5;
        // 5: exception alone (fetch fault) lands in lane 0
        vecs[5] = blank();
        vecs[5].priv = 2'd1; vecs[5].exv = 1; vecs[5].expc = 64'h80000100;
        vecs[5].exp_rec[0] = rec(0, 1, 5, 64'h80000100, 0, 0, 0, 1);
        vecs[5].exp_instret = 5;
        // 6: lane 1 commit plus exception
        vecs[6] = blank();
        vecs[6].cv = 2'b10; vecs[6].pc[1] = 64'h80000200; vecs[6].insn[1] = 32'h00a00513;
        vecs[6].rd[1] = 10; vecs[6].wd[1] = 64'hA; vecs[6].exv = 1;
        vecs[6].expc = 64'h80000204; vecs[6].exinsn = 32'h00100073;
        vecs[6].exp_rec[0] = rec(1, 0, 5, 64'h80000200, 32'h00a00513, 10, 64'hA, 3);
        vecs[6].exp_rec[1] = rec(0, 1, 6, 64'h80000204, 32'h00100073, 0, 0, 3);
        vecs[6].exp_instret = 6;
        // 7: idle, previous records must not persist
        vecs[7] = blank(); vecs[7].exp_instret = 6;
        // 8: full commit plus exception -> trap dropped, overflow sticky
        vecs[8] = blank();
        vecs[8].cv = 2'b11;
        vecs[8].pc[0] = 64'h80000300; vecs[8].insn[0] = 32'h00b00593; vecs[8].rd[0] = 11; vecs[8].wd[0] = 64'hB;
        vecs[8].pc[1] = 64'h80000304; vecs[8].insn[1] = 32'h00c00613; vecs[8].rd[1] = 12; vecs[8].wd[1] = 64'hC;
        vecs[8].exv = 1; vecs[8].expc = 64'h80000308; vecs[8].exinsn = 32'h00000073;
        vecs[8].exp_rec[0] = rec(1, 0, 6, 64'h80000300, 32'h00b00593, 11, 64'hB, 3);
        vecs[8].exp_rec[1] = rec(1, 0, 7, 64'h80000304, 32'h00c00613, 12, 64'hC, 3);
        vecs[8].exp_instret = 8; vecs[8].exp_ovf = 1;
        // 9: idle, overflow holds
        vecs[9] = blank(); vecs[9].exp_instret = 8; vecs[9].exp_ovf = 1;

        idle_inputs();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i); #1;
            chk_rec("reset_idle_rvfi", zero_recs);
            chk_u64("reset_idle_instret", instret_o, 64'd0);
            chk_u64("reset_idle_overflow", 64'(overflow_o), 64'd0);
        end

        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            drive(vecs[i]);
            @(posedge clk_i); #1;
            chk_rec($sformatf("vec%0d_rvfi", i), vecs[i].exp_rec);
            chk_u64($sformatf("vec%0d_instret", i), instret_o, vecs[i].exp_instret);
            chk_u64($sformatf("vec%0d_overflow", i), 64'(overflow_o), 64'(vecs[i].exp_ovf));
        end

        // instret wrap via backdoor preload
        @(negedge clk_i);
        dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        drive(vecs[3]);
        @(posedge clk_i); #1;
        tmp = '0;
        tmp[0] = rec(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h80000008, 32'h00100113, 2, 7, 3);
        tmp[1] = rec(1, 0, 64'd0, 64'h8000000C, 32'h00208193, 3, 9, 3);
        chk_rec("wrap_rvfi", tmp);
        chk_u64("wrap_instret", instret_o, 64'd1);

        // reset asserted during a commit cycle discards that cycle
        @(negedge clk_i);
        drive(vecs[8]);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk_rec("midrst_rvfi", zero_recs);
        chk_u64("midrst_instret", instret_o, 64'd0);
        chk_u64("midrst_overflow", 64'(overflow_o), 64'd0);

        // first record after reset restarts at order 0
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(vecs[1]);
        @(posedge clk_i); #1;
        tmp = '0;
        tmp[0] = rec(1, 0, 0, 64'h80000000, 32'h00500093, 1, 5, 3);
        chk_rec("postrst_rvfi", tmp);
        chk_u64("postrst_instret", instret_o, 64'd1);

        @(negedge clk_i);
        idle_inputs();
        @(posedge clk_i); #1;
        chk_rec("postrst_idle_rvfi", zero_recs);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
